// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample chain: sample type and
// channel-index width helper.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 24;

    typedef logic [AUDIO_SAMPLE_W-1:0] audio_sample_t;

    // A one-channel stream still carries a 1-bit channel tag.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_fifo_mem.sv
// Storage for the audio stream FIFO: {chan, data} entries with synchronous
// write and asynchronous read.
module audio_fifo_mem #(
    parameter int DATA_W = 24,
    parameter int CHAN_W = 1,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAN_W-1:0] wr_chan,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAN_W-1:0] rd_chan,
    output logic [DATA_W-1:0] rd_data
);

    logic [CHAN_W+DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_chan, wr_data};
        end
    end

    assign {rd_chan, rd_data} = mem[rd_addr];

endmodule

// File: rtl/audio_stream_fifo.sv
// Multi-channel sample FIFO with channel/end-of-frame tagging and an optional
// frame-aligned drop mode for sources that cannot be stalled.
module audio_stream_fifo
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_SAMPLE_W,
    parameter int N_CHANNELS = 2,
    parameter int DEPTH      = 8,
    parameter int DROP_MODE  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [DATA_W-1:0]               i_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [DATA_W-1:0]               o_data,
    output logic [chan_w(N_CHANNELS)-1:0]   o_chan,
    output logic                            o_last,
    output logic [$clog2(DEPTH):0]          o_level,
    output logic [15:0]                     o_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = chan_w(N_CHANNELS);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] FRAME_L = LW'(N_CHANNELS);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);

    logic [LW-1:0] wr_ptr, rd_ptr, level;
    logic [CW-1:0] in_chan;
    logic          dropping;
    logic          full, empty, accept, pop, wr_en;
    logic          frame_room, drop_now, new_drop, in_wrap;

    // Extra MSB on the pointers distinguishes full from empty.
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign o_valid = !empty;
    assign o_level = level;
    assign o_ready = (DROP_MODE != 0) ? 1'b1 : !full;

    assign accept     = i_valid && o_ready;
    assign pop        = o_valid && i_ready;
    assign frame_room = (DEPTH_L - level) >= FRAME_L;
    assign in_wrap    = (in_chan == LAST_CH);

    // Admission is decided once per frame at ch0 and carried by the flag for
    // the remaining channels, so frames are stored or discarded whole.
    always_comb begin
        drop_now = 1'b0;
        new_drop = 1'b0;
        if (DROP_MODE != 0) begin
            if (in_chan == '0) begin
                drop_now = !frame_room;
                new_drop = accept && !frame_room;
            end else begin
                drop_now = dropping;
            end
        end
    end

    assign wr_en = accept && !drop_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            in_chan      <= '0;
            dropping     <= 1'b0;
            o_drop_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            if (accept) begin
                in_chan  <= in_wrap ? '0 : in_chan + CW'(1);
                dropping <= in_wrap ? 1'b0 : drop_now;
            end
            if (new_drop && o_drop_count != 16'hFFFF) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end
    end

    audio_fifo_mem #(
        .DATA_W (DATA_W),
        .CHAN_W (CW),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_chan (in_chan),
        .wr_data (i_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_chan (o_chan),
        .rd_data (o_data)
    );

    assign o_last = (o_chan == LAST_CH);

endmodule

// File: tb/tb_audio_stream_fifo.sv
// Bench for audio_stream_fifo: one backpressure and one drop-mode instance
// share stimulus; a queue model is compared every cycle, plus literal checks.
module tb_audio_stream_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [23:0] i_data = '0;

    logic        o_ready0, o_valid0, o_chan0, o_last0;
    logic [23:0] o_data0;
    logic [3:0]  o_level0;
    logic [15:0] o_drop0;
    logic        o_ready1, o_valid1, o_chan1, o_last1;
    logic [23:0] o_data1;
    logic [3:0]  o_level1;
    logic [15:0] o_drop1;

    audio_stream_fifo #(.DATA_W(24), .N_CHANNELS(2), .DEPTH(8), .DROP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
        .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0), .o_chan(o_chan0),
        .o_last(o_last0), .o_level(o_level0), .o_drop_count(o_drop0)
    );

    audio_stream_fifo #(.DATA_W(24), .N_CHANNELS(2), .DEPTH(8), .DROP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data),
        .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1), .o_chan(o_chan1),
        .o_last(o_last1), .o_level(o_level1), .o_drop_count(o_drop1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Model: a queue of {chan, data} per instance; frames in drop mode are
    // admitted at ch0 only if the whole frame fits.
    logic [24:0] q0[$];
    logic [24:0] q1[$];
    int          mch[2];
    bit          mdrop[2];
    int          mdc[2];
    bit          started = 1'b0;
    int          dpops = 0;

    task automatic mstep(input int m);
        int sz;
        bit push, popn, acc;
        logic [24:0] ent;
        sz   = (m == 0) ? q0.size() : q1.size();
        popn = (sz > 0) && i_ready;
        push = 1'b0;
        acc  = 1'b0;
        ent  = {mch[m][0], i_data};
        if (i_valid) begin
            if (m == 0) begin
                acc  = (sz < 8);
                push = acc;
            end else begin
                acc = 1'b1;
                if (mch[m] == 0) begin
                    mdrop[m] = (8 - sz) < 2;
                    if (mdrop[m] && mdc[m] < 65535) mdc[m]++;
                end
                push = !mdrop[m];
            end
            if (acc) mch[m] = (mch[m] + 1) % 2;
        end
        if (m == 0) begin
            if (popn) void'(q0.pop_front());
            if (push) q0.push_back(ent);
        end else begin
            if (popn) void'(q1.pop_front());
            if (push) q1.push_back(ent);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int m = 0; m < 2; m++) begin
                mch[m]   = 0;
                mdrop[m] = 1'b0;
                mdc[m]   = 0;
            end
            started = 1'b1;
        end else begin
            mstep(0);
            mstep(1);
        end
    end

    task automatic cmp(input int m, input logic ordy, input logic ov, input logic [23:0] od,
                       input logic oc, input logic ol, input logic [3:0] lv, input logic [15:0] dc);
        int sz;
        logic [24:0] hd;
        string p;
        p  = (m == 0) ? "m0" : "m1";
        sz = (m == 0) ? q0.size() : q1.size();
        chk({p, ".level"}, 32'(lv), 32'(sz));
        chk({p, ".valid"}, 32'(ov), 32'(sz != 0));
        chk({p, ".ready"}, 32'(ordy), (m == 1) ? 32'd1 : 32'(sz < 8));
        chk({p, ".drops"}, 32'(dc), 32'(mdc[m]));
        if (sz > 0) begin
            hd = (m == 0) ? q0[0] : q1[0];
            chk({p, ".data"}, 32'(od), 32'(hd[23:0]));
            chk({p, ".chan"}, 32'(oc), 32'(hd[24]));
            chk({p, ".last"}, 32'(ol), 32'(hd[24]));
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp(0, o_ready0, o_valid0, o_data0, o_chan0, o_last0, o_level0, o_drop0);
            cmp(1, o_ready1, o_valid1, o_data1, o_chan1, o_last1, o_level1, o_drop1);
            if (o_valid0 && i_ready) dpops++;
        end
    end

    task automatic cyc(input logic v, input logic [23:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 24'h0, 1'b0);
        cyc(1'b0, 24'h0, 1'b0);
        rst = 1'b0;
    endtask

    int  sent, cycles, pops_base;
    bit  v, r, acc;

    initial begin
        // Reset state
        do_reset();
        chk("rst.valid0", 32'(o_valid0), 0);
        chk("rst.level0", 32'(o_level0), 0);
        chk("rst.ready0", 32'(o_ready0), 1);
        chk("rst.ready1", 32'(o_ready1), 1);
        chk("rst.drops1", 32'(o_drop1), 0);

        // Stereo pass-through
        cyc(1'b1, 24'h000001, 1'b1);
        chk("t1.data0", 32'(o_data0), 32'h1);
        chk("t1.chan0", 32'(o_chan0), 0);
        chk("t1.last0", 32'(o_last0), 0);
        chk("t1.level0", 32'(o_level0), 1);
        cyc(1'b1, 24'h000002, 1'b1);
        chk("t1.data1", 32'(o_data0), 32'h2);
        chk("t1.chan1", 32'(o_chan0), 1);
        chk("t1.last1", 32'(o_last0), 1);
        chk("t1.level1", 32'(o_level0), 1);
        cyc(1'b0, 24'h0, 1'b1);
        chk("t1.empty", 32'(o_valid0), 0);

        // Fill to full under backpressure, then drain
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 24'(32'h100 + k), 1'b0);
            if (k == 7) begin
                chk("t2.ready_full", 32'(o_ready0), 0);
                chk("t2.level_full", 32'(o_level0), 8);
            end
        end
        chk("t2.level_after", 32'(o_level0), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t2.drain", 32'(o_data0), 32'h100 + k);
            cyc(1'b0, 24'h0, 1'b1);
        end
        chk("t2.level_end", 32'(o_level0), 0);

        // Simultaneous push/pop at level 4 across pointer wrap
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 24'(32'h200 + k), 1'b0);
        chk("t3.level_pre", 32'(o_level0), 4);
        for (int j = 1; j <= 12; j++) begin
            cyc(1'b1, 24'(32'h203 + j), 1'b1);
            chk("t3.level", 32'(o_level0), 4);
            chk("t3.head", 32'(o_data0), 32'h200 + j);
        end

        // Drop mode: fifth frame discarded whole
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 24'(32'h300 + k), 1'b0);
            chk("t4.ready1", 32'(o_ready1), 1);
        end
        chk("t4.level1", 32'(o_level1), 8);
        chk("t4.drops1", 32'(o_drop1), 1);
        for (int k = 0; k < 8; k++) begin
            chk("t4.drain", 32'(o_data1), 32'h300 + k);
            cyc(1'b0, 24'h0, 1'b1);
        end
        chk("t4.level_end", 32'(o_level1), 0);
        cyc(1'b1, 24'h0003A0, 1'b0);
        cyc(1'b1, 24'h0003A1, 1'b0);
        chk("t4.f6_data0", 32'(o_data1), 32'h3A0);
        chk("t4.f6_chan0", 32'(o_chan1), 0);
        cyc(1'b0, 24'h0, 1'b1);
        chk("t4.f6_data1", 32'(o_data1), 32'h3A1);
        chk("t4.f6_chan1", 32'(o_chan1), 1);
        chk("t4.f6_last1", 32'(o_last1), 1);
        cyc(1'b0, 24'h0, 1'b1);
        chk("t4.drops_end", 32'(o_drop1), 1);

        // Reset one cycle after a ch0 push
        do_reset();
        cyc(1'b1, 24'h000500, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 24'h0, 1'b0);
        chk("t5.valid", 32'(o_valid0), 0);
        chk("t5.level", 32'(o_level0), 0);
        rst = 1'b0;
        cyc(1'b1, 24'h000555, 1'b0);
        chk("t5.chan0", 32'(o_chan0), 0);
        chk("t5.data0", 32'(o_data0), 32'h555);
        chk("t5.chan1", 32'(o_chan1), 0);

        // Random soak
        do_reset();
        pops_base = dpops;
        sent   = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2) != 0);
            acc = v && o_ready0;
            cyc(v, 24'(32'h10000 + sent), r);
            if (acc) sent++;
            cycles++;
        end
        while (o_valid0 && cycles < 20000) begin
            cyc(1'b0, 24'h0, 1'b1);
            cycles++;
        end
        chk("soak.sent", 32'(sent), 1000);
        chk("soak.pops", 32'(dpops - pops_base), 1000);
        chk("soak.level", 32'(o_level0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
